// File: rtl/store_buffer_pkg.sv
// Shared widths, entry/commit payload types and the byte-lane mask helper
// for the store buffer and its forwarding unit.
package store_buffer_pkg;

  localparam int unsigned STBUF_DEPTH    = 16;
  localparam int unsigned COMMIT_WIDTH   = 2;
  localparam int unsigned ROB_ID_WIDTH   = 6;
  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned SIZE_WIDTH     = 2;
  localparam int unsigned BUS_DATA_WIDTH = 32;
  localparam int unsigned BYTES          = BUS_DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH      = $clog2(STBUF_DEPTH);
  localparam int unsigned PTR_WIDTH      = IDX_WIDTH + 1;

  typedef struct packed {
    logic                      valid;
    logic                      committed;
    logic [ROB_ID_WIDTH-1:0]   rob_id;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [SIZE_WIDTH-1:0]     size;
    logic [BUS_DATA_WIDTH-1:0] data;
  } stbuf_entry_t;

  typedef struct packed {
    logic                                       enable;
    logic                                       flush;
    logic [COMMIT_WIDTH-1:0][ROB_ID_WIDTH-1:0]  committed_rob_id;
    logic [COMMIT_WIDTH-1:0]                    committed_rob_id_valid;
  } commit_feedback_pack_t;

  // Lanes touched inside the word; bytes running past the word end are dropped.
  function automatic logic [BYTES-1:0] byte_mask(input logic [SIZE_WIDTH-1:0] size,
                                                 input logic [1:0]            off);
    logic [BYTES-1:0] base;
    case (size)
      2'd0:    base = BYTES'(1);
      2'd1:    base = BYTES'(3);
      default: base = '1;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/stbuf_forward_unit.sv
// Combinational byte merge: each load lane takes the youngest valid entry
// covering it, otherwise the bus byte.
module stbuf_forward_unit
  import store_buffer_pkg::*;
(
  input  logic [STBUF_DEPTH-1:0]                     i_valid,
  input  logic [STBUF_DEPTH-1:0][ADDR_WIDTH-1:0]     i_addr,
  input  logic [STBUF_DEPTH-1:0][SIZE_WIDTH-1:0]     i_size,
  input  logic [STBUF_DEPTH-1:0][BUS_DATA_WIDTH-1:0] i_data,
  input  logic [IDX_WIDTH-1:0]                       i_head_idx,
  input  logic [ADDR_WIDTH-1:0]                      i_load_addr,
  input  logic [SIZE_WIDTH-1:0]                      i_load_size,
  input  logic [BUS_DATA_WIDTH-1:0]                  i_bus_data,
  output logic [BUS_DATA_WIDTH-1:0]                  o_merged_c
);

  logic [BYTES-1:0]                          w_load_mask;
  logic [STBUF_DEPTH-1:0][BYTES-1:0]         w_hit;
  logic [STBUF_DEPTH-1:0][BUS_DATA_WIDTH-1:0] w_lane_data;
  logic [IDX_WIDTH-1:0]                      w_order [STBUF_DEPTH];

  assign w_load_mask = byte_mask(i_load_size, i_load_addr[1:0]);

  for (genvar g = 0; g < STBUF_DEPTH; g++) begin : g_ent
    // Per-entry lanes that hit the load word, with data moved onto its byte lanes.
    assign w_hit[g] = (i_valid[g] && (i_addr[g][ADDR_WIDTH-1:2] == i_load_addr[ADDR_WIDTH-1:2]))
                      ? (byte_mask(i_size[g], i_addr[g][1:0]) & w_load_mask) : '0;
    assign w_lane_data[g] = i_data[g] << {i_addr[g][1:0], 3'b000};
    assign w_order[g]     = i_head_idx + IDX_WIDTH'(g);
  end

  // Walk oldest to youngest so the youngest hit wins each lane.
  always_comb begin
    o_merged_c = i_bus_data;
    for (int k = 0; k < STBUF_DEPTH; k++) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_hit[w_order[k]][b]) begin
          o_merged_c[8*b +: 8] = w_lane_data[w_order[k]][8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: holds stores until commit, drains them to the bus,
// and forwards buffered bytes to same-cycle load reads.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROB_ID_WIDTH-1:0]   exlsu_stbuf_rob_id,
  input  logic [ADDR_WIDTH-1:0]     exlsu_stbuf_write_addr,
  input  logic [SIZE_WIDTH-1:0]     exlsu_stbuf_write_size,
  input  logic [BUS_DATA_WIDTH-1:0] exlsu_stbuf_write_data,
  input  logic                      exlsu_stbuf_push,
  output logic                      stbuf_exlsu_full,
  input  logic [ADDR_WIDTH-1:0]     exlsu_stbuf_read_addr,
  input  logic [SIZE_WIDTH-1:0]     exlsu_stbuf_read_size,
  input  logic                      exlsu_stbuf_read_req,
  output logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data,
  output logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data_feedback,
  output logic                      stbuf_exlsu_bus_ready,
  output logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr,
  output logic [SIZE_WIDTH-1:0]     stbuf_bus_read_size,
  output logic                      stbuf_bus_read_req,
  input  logic [BUS_DATA_WIDTH-1:0] bus_stbuf_read_data,
  input  logic                      bus_stbuf_read_ready,
  output logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr,
  output logic [SIZE_WIDTH-1:0]     stbuf_bus_write_size,
  output logic [BUS_DATA_WIDTH-1:0] stbuf_bus_write_data,
  output logic                      stbuf_bus_write_req,
  input  logic                      bus_stbuf_write_ack,
  input  commit_feedback_pack_t     commit_feedback_pack
);

  stbuf_entry_t [STBUF_DEPTH-1:0] r_entries;
  stbuf_entry_t [STBUF_DEPTH-1:0] w_entries_nx;
  logic [PTR_WIDTH-1:0]           r_head, r_tail, r_commit_cnt;
  logic [PTR_WIDTH-1:0]           w_head_nx, w_tail_nx, w_cnt_nx;
  logic [PTR_WIDTH-1:0]           w_cnt_mid, w_new_commits, w_occ;
  logic [IDX_WIDTH-1:0]           w_head_idx, w_tail_idx;
  logic                           w_full, w_flush, w_push_ok, w_pop;

  logic [STBUF_DEPTH-1:0]                     w_ent_valid;
  logic [STBUF_DEPTH-1:0][ADDR_WIDTH-1:0]     w_ent_addr;
  logic [STBUF_DEPTH-1:0][SIZE_WIDTH-1:0]     w_ent_size;
  logic [STBUF_DEPTH-1:0][BUS_DATA_WIDTH-1:0] w_ent_data;
  logic [BUS_DATA_WIDTH-1:0]                  w_merged, w_shifted, w_size_mask;
  logic                                       w_rd_ready;

  assign w_head_idx = r_head[IDX_WIDTH-1:0];
  assign w_tail_idx = r_tail[IDX_WIDTH-1:0];
  assign w_occ      = r_tail - r_head;
  assign w_full     = (w_occ == PTR_WIDTH'(STBUF_DEPTH));
  assign w_flush    = commit_feedback_pack.enable && commit_feedback_pack.flush;
  assign w_push_ok  = exlsu_stbuf_push && !w_full && !w_flush;
  assign w_pop      = stbuf_bus_write_req && bus_stbuf_write_ack;

  assign stbuf_exlsu_full     = w_full;
  assign stbuf_bus_write_req  = r_entries[w_head_idx].valid && r_entries[w_head_idx].committed;
  assign stbuf_bus_write_addr = r_entries[w_head_idx].addr;
  assign stbuf_bus_write_size = r_entries[w_head_idx].size;
  assign stbuf_bus_write_data = r_entries[w_head_idx].data;

  // Next state: commit marks, then flush trim, then pop and push.
  always_comb begin
    w_entries_nx  = r_entries;
    w_new_commits = '0;
    for (int i = 0; i < STBUF_DEPTH; i++) begin
      if (commit_feedback_pack.enable && r_entries[i].valid && !r_entries[i].committed) begin
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
          if (commit_feedback_pack.committed_rob_id_valid[c] &&
              (commit_feedback_pack.committed_rob_id[c] == r_entries[i].rob_id)) begin
            w_entries_nx[i].committed = 1'b1;
          end
        end
        if (w_entries_nx[i].committed) begin
          w_new_commits = w_new_commits + PTR_WIDTH'(1);
        end
      end
    end
    w_cnt_mid = r_commit_cnt + w_new_commits;

    if (w_flush) begin
      for (int i = 0; i < STBUF_DEPTH; i++) begin
        if (!w_entries_nx[i].committed) begin
          w_entries_nx[i] = '0;
        end
      end
    end

    if (w_pop) begin
      w_entries_nx[w_head_idx] = '0;
    end

    if (w_push_ok) begin
      w_entries_nx[w_tail_idx].valid     = 1'b1;
      w_entries_nx[w_tail_idx].committed = 1'b0;
      w_entries_nx[w_tail_idx].rob_id    = exlsu_stbuf_rob_id;
      w_entries_nx[w_tail_idx].addr      = exlsu_stbuf_write_addr;
      w_entries_nx[w_tail_idx].size      = exlsu_stbuf_write_size;
      w_entries_nx[w_tail_idx].data      = exlsu_stbuf_write_data;
    end

    w_head_nx = r_head + PTR_WIDTH'(w_pop);
    w_cnt_nx  = w_cnt_mid - PTR_WIDTH'(w_pop);
    // head + committed count is invariant across a pop, so the pre-pop head is used.
    w_tail_nx = w_flush ? (r_head + w_cnt_mid) : (r_tail + PTR_WIDTH'(w_push_ok));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_entries    <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_commit_cnt <= '0;
    end else begin
      r_entries    <= w_entries_nx;
      r_head       <= w_head_nx;
      r_tail       <= w_tail_nx;
      r_commit_cnt <= w_cnt_nx;
    end
  end

  for (genvar g = 0; g < STBUF_DEPTH; g++) begin : g_fwd_in
    assign w_ent_valid[g] = r_entries[g].valid;
    assign w_ent_addr[g]  = r_entries[g].addr;
    assign w_ent_size[g]  = r_entries[g].size;
    assign w_ent_data[g]  = r_entries[g].data;
  end

  stbuf_forward_unit u_fwd (
    .i_valid     (w_ent_valid),
    .i_addr      (w_ent_addr),
    .i_size      (w_ent_size),
    .i_data      (w_ent_data),
    .i_head_idx  (w_head_idx),
    .i_load_addr (exlsu_stbuf_read_addr),
    .i_load_size (exlsu_stbuf_read_size),
    .i_bus_data  (bus_stbuf_read_data),
    .o_merged_c  (w_merged)
  );

  // Load side: request passthrough, data outputs held at zero when not valid.
  assign stbuf_bus_read_addr   = exlsu_stbuf_read_addr;
  assign stbuf_bus_read_size   = exlsu_stbuf_read_size;
  assign stbuf_bus_read_req    = exlsu_stbuf_read_req;
  assign w_rd_ready            = exlsu_stbuf_read_req && bus_stbuf_read_ready;
  assign stbuf_exlsu_bus_ready = w_rd_ready;
  assign stbuf_exlsu_bus_data  = w_rd_ready ? bus_stbuf_read_data : '0;
  assign w_shifted             = w_merged >> {exlsu_stbuf_read_addr[1:0], 3'b000};

  always_comb begin
    case (exlsu_stbuf_read_size)
      2'd0:    w_size_mask = BUS_DATA_WIDTH'(32'h0000_00FF);
      2'd1:    w_size_mask = BUS_DATA_WIDTH'(32'h0000_FFFF);
      default: w_size_mask = '1;
    endcase
  end

  assign stbuf_exlsu_bus_data_feedback = w_rd_ready ? (w_shifted & w_size_mask) : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed sequences, a load table and a
// randomized run against a queue-based reference model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic [ROB_ID_WIDTH-1:0]   p_rob;
  logic [ADDR_WIDTH-1:0]     p_addr;
  logic [SIZE_WIDTH-1:0]     p_size;
  logic [BUS_DATA_WIDTH-1:0] p_data;
  logic                      p_push;
  logic                      full;
  logic [ADDR_WIDTH-1:0]     ld_addr;
  logic [SIZE_WIDTH-1:0]     ld_size;
  logic                      ld_req;
  logic [BUS_DATA_WIDTH-1:0] o_bus_data, o_fb;
  logic                      o_ready;
  logic [ADDR_WIDTH-1:0]     br_addr;
  logic [SIZE_WIDTH-1:0]     br_size;
  logic                      br_req;
  logic [BUS_DATA_WIDTH-1:0] rdata;
  logic                      rrdy;
  logic [ADDR_WIDTH-1:0]     wa;
  logic [SIZE_WIDTH-1:0]     ws;
  logic [BUS_DATA_WIDTH-1:0] wd;
  logic                      wreq, ack;
  commit_feedback_pack_t     cfp;

  store_buffer dut (
    .clk(clk), .rst(rst),
    .exlsu_stbuf_rob_id(p_rob), .exlsu_stbuf_write_addr(p_addr),
    .exlsu_stbuf_write_size(p_size), .exlsu_stbuf_write_data(p_data),
    .exlsu_stbuf_push(p_push), .stbuf_exlsu_full(full),
    .exlsu_stbuf_read_addr(ld_addr), .exlsu_stbuf_read_size(ld_size),
    .exlsu_stbuf_read_req(ld_req), .stbuf_exlsu_bus_data(o_bus_data),
    .stbuf_exlsu_bus_data_feedback(o_fb), .stbuf_exlsu_bus_ready(o_ready),
    .stbuf_bus_read_addr(br_addr), .stbuf_bus_read_size(br_size),
    .stbuf_bus_read_req(br_req), .bus_stbuf_read_data(rdata),
    .bus_stbuf_read_ready(rrdy), .stbuf_bus_write_addr(wa),
    .stbuf_bus_write_size(ws), .stbuf_bus_write_data(wd),
    .stbuf_bus_write_req(wreq), .bus_stbuf_write_ack(ack),
    .commit_feedback_pack(cfp)
  );

  int tests = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    p_push = 0; p_rob = '0; p_addr = '0; p_size = '0; p_data = '0;
    ld_req = 0; ld_addr = '0; ld_size = '0; rdata = '0; rrdy = 0;
    ack = 0; cfp = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; idle(); step(); step(); rst = 0;
  endtask

  task automatic push(input logic [5:0] rob, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] d);
    p_push = 1; p_rob = rob; p_addr = a; p_size = sz; p_data = d;
    step();
    p_push = 0;
  endtask

  task automatic commit(input logic [5:0] id0, input logic v0, input logic [5:0] id1,
                        input logic v1, input logic fl);
    cfp = '0; cfp.enable = 1; cfp.flush = fl;
    cfp.committed_rob_id[0] = id0; cfp.committed_rob_id_valid[0] = v0;
    cfp.committed_rob_id[1] = id1; cfp.committed_rob_id_valid[1] = v1;
    step();
    cfp = '0;
  endtask

  task automatic chk_load(input string name, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] bus, input logic [31:0] exp);
    ld_req = 1; rrdy = 1; ld_addr = a; ld_size = sz; rdata = bus;
    #1;
    chk(name, o_fb, exp);
    ld_req = 0; rrdy = 0;
  endtask

  // Reference model: queue of buffered stores, oldest first.
  typedef struct {
    logic [5:0]  rob;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    logic        committed;
  } mst_t;
  mst_t q[$];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Load value from byte addresses: youngest covering store, else bus lane.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic [31:0] bus);
    logic [31:0] r = '0;
    for (int j = 0; j < nbytes(sz); j++) begin
      logic [31:0] ba;
      logic [7:0]  v;
      logic [31:0] d;
      if (int'(a[1:0]) + j >= 4) continue;
      ba = a + 32'(j);
      v  = bus[8*int'(ba[1:0]) +: 8];
      for (int k = 0; k < q.size(); k++) begin
        if (ba >= q[k].addr && ba < q[k].addr + 32'(nbytes(q[k].size)) &&
            int'(q[k].addr[1:0]) + int'(ba - q[k].addr) < 4) begin
          d = q[k].data;
          v = d[8*int'(ba - q[k].addr) +: 8];
        end
      end
      r[8*j +: 8] = v;
    end
    return r;
  endfunction

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] bus;
    logic        rdy;
    logic [31:0] exp_fb;
  } ld_vec_t;
  ld_vec_t vecs[9];

  initial begin
    logic [5:0] next_rob;
    int         fu;
    int         n;
    logic       exp_wreq, exp_full, exp_rdy, en_fl;

    vecs[0] = '{"lw_merge",     32'h100, 2'd2, 32'h55667788, 1'b1, 32'h5566AA88};
    vecs[1] = '{"lbu_fwd",      32'h101, 2'd0, 32'h55667788, 1'b1, 32'h000000AA};
    vecs[2] = '{"lbu_bus",      32'h100, 2'd0, 32'h55667788, 1'b1, 32'h00000088};
    vecs[3] = '{"lh_lo",        32'h100, 2'd1, 32'h55667788, 1'b1, 32'h0000AA88};
    vecs[4] = '{"lh_hi",        32'h102, 2'd1, 32'h55667788, 1'b1, 32'h00005566};
    vecs[5] = '{"lw_other",     32'h104, 2'd2, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[6] = '{"lbu_top",      32'h103, 2'd0, 32'h55667788, 1'b1, 32'h00000055};
    vecs[7] = '{"lw_misalign",  32'h101, 2'd2, 32'h55667788, 1'b1, 32'h005566AA};
    vecs[8] = '{"lw_notready",  32'h100, 2'd2, 32'h55667788, 1'b0, 32'h00000000};

    rst = 1; idle();
    repeat (3) step();
    rst = 0;
    chk("rst_full", 32'(full), 0);
    chk("rst_wreq", 32'(wreq), 0);
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_bus_data", o_bus_data, 0);
    chk("rst_fb", o_fb, 0);

    // Uncommitted word store forwards entirely over a zero bus word.
    push(6'd1, 32'h100, 2'd2, 32'h11223344);
    chk_load("t1_lw", 32'h100, 2'd2, 32'h0, 32'h11223344);
    chk("t1_wreq", 32'(wreq), 0);

    // Byte store merged over bus data, table driven.
    do_reset();
    push(6'd2, 32'h101, 2'd0, 32'h123456AA);
    for (int i = 0; i < 9; i++) begin
      ld_req = 1; rrdy = vecs[i].rdy; ld_addr = vecs[i].addr; ld_size = vecs[i].size;
      rdata = vecs[i].bus;
      #1;
      chk({vecs[i].name, "_fb"}, o_fb, vecs[i].exp_fb);
      chk({vecs[i].name, "_ready"}, 32'(o_ready), 32'(vecs[i].rdy));
      chk({vecs[i].name, "_raw"}, o_bus_data, vecs[i].rdy ? vecs[i].bus : 32'h0);
      ld_req = 0; rrdy = 0;
    end

    // Fill to full, dropped 17th push, one drain frees a slot.
    do_reset();
    for (int i = 0; i < 16; i++) push(6'(i), 32'h300 + 32'(4*i), 2'd2, 32'(i));
    chk("t3_full16", 32'(full), 1);
    push(6'd16, 32'h400, 2'd2, 32'hCAFE0000);
    chk("t3_full17", 32'(full), 1);
    chk_load("t3_drop_fwd", 32'h400, 2'd2, 32'h12345678, 32'h12345678);
    commit(6'd0, 1, 6'd0, 0, 0);
    chk("t3_wreq", 32'(wreq), 1);
    chk("t3_waddr", wa, 32'h300);
    ack = 1; step(); ack = 0;
    chk("t3_full_after", 32'(full), 0);
    chk("t3_wreq_after", 32'(wreq), 0);

    // Commit rob 3 with a flush: 4 and 5 vanish, 3 drains.
    do_reset();
    push(6'd3, 32'h500, 2'd2, 32'hA3);
    push(6'd4, 32'h504, 2'd2, 32'hA4);
    push(6'd5, 32'h508, 2'd2, 32'hA5);
    commit(6'd3, 1, 6'd0, 0, 1);
    chk("t4_wreq", 32'(wreq), 1);
    chk("t4_waddr", wa, 32'h500);
    chk("t4_wdata", wd, 32'hA3);
    chk_load("t4_no4", 32'h504, 2'd2, 32'h77, 32'h77);
    chk_load("t4_no5", 32'h508, 2'd2, 32'h88, 32'h88);
    chk_load("t4_keep3", 32'h500, 2'd2, 32'h0, 32'hA3);
    ack = 1; step(); ack = 0;
    chk("t4_wreq_done", 32'(wreq), 0);

    // Two stores to one word: youngest forwards, drain is in order.
    do_reset();
    push(6'd10, 32'h200, 2'd2, 32'h1);
    push(6'd11, 32'h200, 2'd2, 32'h2);
    chk_load("t5_young", 32'h200, 2'd2, 32'h0, 32'h2);
    commit(6'd10, 1, 6'd11, 1, 0);
    chk("t5_wreq1", 32'(wreq), 1);
    chk("t5_wdata1", wd, 32'h1);
    ack = 1; step(); ack = 0;
    chk("t5_wreq2", 32'(wreq), 1);
    chk("t5_wdata2", wd, 32'h2);
    chk_load("t5_young2", 32'h200, 2'd2, 32'h0, 32'h2);
    ack = 1; step(); ack = 0;
    chk("t5_wreq_done", 32'(wreq), 0);
    chk_load("t5_empty", 32'h200, 2'd2, 32'h5A, 32'h5A);

    // Reset wins over an ack mid-drain.
    do_reset();
    push(6'd1, 32'h600, 2'd2, 32'h66);
    commit(6'd1, 1, 6'd0, 0, 0);
    chk("t6_wreq_pre", 32'(wreq), 1);
    rst = 1; ack = 1; step(); rst = 0; ack = 0;
    chk("t6_wreq", 32'(wreq), 0);
    chk("t6_full", 32'(full), 0);
    chk_load("t6_gone", 32'h600, 2'd2, 32'h9, 32'h9);

    // Randomized run against the queue model.
    do_reset();
    q.delete();
    next_rob = 6'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      p_push = ($urandom % 3) != 0;
      p_rob  = next_rob;
      p_addr = 32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      p_size = 2'($urandom_range(0, 2));
      p_data = $urandom;
      cfp = '0;
      cfp.enable = ($urandom % 8) != 0;
      cfp.flush  = ($urandom % 20) == 0;
      fu = 0;
      while (fu < q.size() && q[fu].committed) fu++;
      n = $urandom % 3;
      for (int c = 0; c < 2; c++) begin
        if (c < n && fu + c < q.size()) begin
          cfp.committed_rob_id[c] = q[fu + c].rob;
          cfp.committed_rob_id_valid[c] = 1'b1;
        end else begin
          cfp.committed_rob_id[c] = 6'($urandom);
        end
      end
      if ($urandom % 2) begin
        cfp.committed_rob_id = {cfp.committed_rob_id[0], cfp.committed_rob_id[1]};
        cfp.committed_rob_id_valid = {cfp.committed_rob_id_valid[0], cfp.committed_rob_id_valid[1]};
      end
      ack     = $urandom % 2;
      ld_req  = ($urandom % 4) != 0;
      rrdy    = ($urandom % 4) != 0;
      ld_addr = 32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      ld_size = 2'($urandom_range(0, 2));
      rdata   = $urandom;
      #2;

      exp_full = (q.size() == 16);
      exp_wreq = (q.size() > 0) && q[0].committed;
      exp_rdy  = ld_req && rrdy;
      chk("rnd_full", 32'(full), 32'(exp_full));
      chk("rnd_wreq", 32'(wreq), 32'(exp_wreq));
      if (exp_wreq) begin
        chk("rnd_waddr", wa, q[0].addr);
        chk("rnd_wsize", 32'(ws), 32'(q[0].size));
        chk("rnd_wdata", wd, q[0].data);
      end
      chk("rnd_ready", 32'(o_ready), 32'(exp_rdy));
      chk("rnd_raw", o_bus_data, exp_rdy ? rdata : 32'h0);
      chk("rnd_fb", o_fb, exp_rdy ? model_load(ld_addr, ld_size, rdata) : 32'h0);
      chk("rnd_rd_pass", {br_addr[29:0], br_size}, {ld_addr[29:0], ld_size});
      chk("rnd_rd_req", 32'(br_req), 32'(ld_req));

      @(posedge clk);
      if (cfp.enable) begin
        for (int c = 0; c < 2; c++) begin
          if (cfp.committed_rob_id_valid[c]) begin
            for (int k = 0; k < q.size(); k++) begin
              if (!q[k].committed && q[k].rob == cfp.committed_rob_id[c]) q[k].committed = 1'b1;
            end
          end
        end
      end
      if (exp_wreq && ack) void'(q.pop_front());
      en_fl = cfp.enable && cfp.flush;
      if (en_fl) begin
        for (int k = q.size() - 1; k >= 0; k--) begin
          if (!q[k].committed) q.delete(k);
        end
      end
      if (p_push && !exp_full && !en_fl) begin
        q.push_back('{p_rob, p_addr, p_size, p_data, 1'b0});
        next_rob = next_rob + 6'd1;
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
